// File: rtl/bnn_bram_load_ctrl_pkg.sv
// ============================================================================
// Module   : bnn_dma_pkg
// Purpose  : Shared types and constants for the BNN BRAM load controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_e;

    localparam int BYTE_SHIFT          = 2;
    localparam int DEFAULT_DEPTH_WORDS = 512;

    function automatic logic [31:0] word_to_byte(input logic [31:0] word_idx);
        return word_idx << BYTE_SHIFT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_bram_load_ctrl_if.sv
// ============================================================================
// Module   : bnn_bram_load_ctrl_if
// Purpose  : AXI-Stream input, BRAM port and compute read bus of the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bnn_bram_load_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
);
    logic [DATA_W-1:0]   s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                s_axis_tready;

    logic                clka;
    logic                rsta;
    logic                ena;
    logic [DATA_W/8-1:0] wea;
    logic [31:0]         addra;
    logic [DATA_W-1:0]   dina;
    logic [DATA_W-1:0]   douta;

    logic                buf_ready;
    logic [CNT_W-1:0]    buf_words;
    logic                err_overflow;
    logic                rd_req;
    logic [CNT_W-1:0]    rd_addr;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                consume_done;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, douta,
               rd_req, rd_addr, consume_done,
        output s_axis_tready, clka, rsta, ena, wea, addra, dina,
               buf_ready, buf_words, err_overflow, rd_valid, rd_data
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, douta,
               rd_req, rd_addr, consume_done,
        input  s_axis_tready, clka, rsta, ena, wea, addra, dina,
               buf_ready, buf_words, err_overflow, rd_valid, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/bnn_bram_load_ctrl.sv
// ============================================================================
// Module   : bnn_bram_load_ctrl
// Purpose  : Loads one AXIS frame into BRAM, then lends the port to compute.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_bram_load_ctrl
    import bnn_dma_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int CNT_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_bram_load_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_READY = READY;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH_WORDS);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    buf_words_q, buf_words_d;
    logic                err_overflow_q, err_overflow_d;
    logic                rd_valid_q, rd_valid_d;

    logic                tready;
    logic                beat;
    logic                ena;
    logic [DATA_W/8-1:0] wea;
    logic [31:0]         addra;
    logic [DATA_W-1:0]   dina;

    // DMA is only accepted outside READY; reset forces every handshake low.
    assign tready = rst && (state_q != S_READY);
    assign beat   = bus.s_axis_tvalid && tready;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        buf_words_d    = buf_words_q;
        err_overflow_d = err_overflow_q;
        rd_valid_d     = 1'b0;
        ena            = 1'b0;
        wea            = '0;
        addra          = '0;
        dina           = '0;

        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        err_overflow_d = 1'b0;
                        ena            = 1'b1;
                        wea            = '1;
                        dina           = bus.s_axis_tdata;
                        if (bus.s_axis_tlast) begin
                            buf_words_d = CNT_W'(1);
                            state_d     = S_READY;
                        end else begin
                            idx_d   = CNT_W'(1);
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        ena   = 1'b1;
                        wea   = '1;
                        addra = word_to_byte(32'(idx_q));
                        dina  = bus.s_axis_tdata;
                        if (bus.s_axis_tlast) begin
                            buf_words_d = idx_q + CNT_W'(1);
                            idx_d       = '0;
                            state_d     = S_READY;
                        end else if (idx_q == LAST_IDX) begin
                            // Buffer full: keep the handshake alive but drop the tail.
                            buf_words_d    = FULL_CNT;
                            err_overflow_d = 1'b1;
                            idx_d          = '0;
                            state_d        = S_DRAIN;
                        end else begin
                            idx_d = idx_q + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (beat && bus.s_axis_tlast) begin
                        state_d = S_READY;
                    end
                end
                S_READY: begin
                    if (bus.rd_req) begin
                        ena        = 1'b1;
                        addra      = word_to_byte(32'(bus.rd_addr));
                        rd_valid_d = 1'b1;
                    end
                    if (bus.consume_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            buf_words_q    <= '0;
            err_overflow_q <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            buf_words_q    <= buf_words_d;
            err_overflow_q <= err_overflow_d;
            rd_valid_q     <= rd_valid_d;
        end
    end

    assign bus.s_axis_tready = tready;
    assign bus.clka          = clk;
    assign bus.rsta          = ~rst;
    assign bus.ena           = ena;
    assign bus.wea           = wea;
    assign bus.addra         = addra;
    assign bus.dina          = dina;

    assign bus.buf_ready     = (state_q == S_READY);
    assign bus.buf_words     = buf_words_q;
    assign bus.err_overflow  = err_overflow_q;
    assign bus.rd_valid      = rd_valid_q;
    // BRAM output register already provides the pipeline stage.
    assign bus.rd_data       = rd_valid_q ? bus.douta : '0;

endmodule

`default_nettype wire

// File: tb/tb_bnn_bram_load_ctrl.sv
// ============================================================================
// Module   : tb_bnn_bram_load_ctrl
// Purpose  : Directed self-checking bench for bnn_bram_load_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_bram_load_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 512;
    localparam int CNT_W  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bnn_bram_load_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    bnn_bram_load_ctrl #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // BRAM model with registered read, plus a log of every write address.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [31:0]       wr_log [$];

    always @(posedge clk) begin
        if (bus.ena) begin
            if (bus.wea == 4'hF) begin
                mem[bus.addra[31:2] % DEPTH] <= bus.dina;
                wr_log.push_back(bus.addra);
            end
            bus.douta <= mem[bus.addra[31:2] % DEPTH];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        @(negedge clk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        n = 0;
        while (!bus.s_axis_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("tready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tready"},    32'(bus.s_axis_tready), 32'd0);
        check({pfx, "_ena"},       32'(bus.ena),           32'd0);
        check({pfx, "_wea"},       32'(bus.wea),           32'd0);
        check({pfx, "_addra"},     bus.addra,              32'd0);
        check({pfx, "_buf_ready"}, 32'(bus.buf_ready),     32'd0);
        check({pfx, "_buf_words"}, 32'(bus.buf_words),     32'd0);
        check({pfx, "_err"},       32'(bus.err_overflow),  32'd0);
        check({pfx, "_rd_valid"},  32'(bus.rd_valid),      32'd0);
        check({pfx, "_rd_data"},   bus.rd_data,            32'd0);
        check({pfx, "_rsta"},      32'(bus.rsta),          32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.consume_done = 1'b1;
        @(negedge clk);
        bus.consume_done = 1'b0;
        check("consume_buf_ready", 32'(bus.buf_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.rd_req        = 1'b0;
        bus.rd_addr       = '0;
        bus.consume_done  = 1'b0;
        bus.douta         = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // 4-beat continuous frame.
        wr_log.delete();
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), i == 3);
        idle_cycles(1);
        check("f4_buf_ready", 32'(bus.buf_ready), 32'd1);
        check("f4_buf_words", 32'(bus.buf_words), 32'd4);
        check("f4_err", 32'(bus.err_overflow), 32'd0);
        check("f4_tready", 32'(bus.s_axis_tready), 32'd0);
        check("f4_nwr", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check($sformatf("f4_addr%0d", i), wr_log[i], 32'(4 * i));

        // Single read of word 2.
        bus.rd_req = 1'b1; bus.rd_addr = 10'd2;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("rd2_valid", 32'(bus.rd_valid), 32'd1);
        check("rd2_data", bus.rd_data, 32'hA2);
        @(negedge clk);
        check("rd2_valid_drop", 32'(bus.rd_valid), 32'd0);

        // Back-to-back reads 0,1,3.
        bus.rd_req = 1'b1; bus.rd_addr = 10'd0;
        @(negedge clk);
        bus.rd_addr = 10'd1;
        check("b2b0_valid", 32'(bus.rd_valid), 32'd1);
        check("b2b0_data", bus.rd_data, 32'hA0);
        @(negedge clk);
        bus.rd_addr = 10'd3;
        check("b2b1_data", bus.rd_data, 32'hA1);
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("b2b3_valid", 32'(bus.rd_valid), 32'd1);
        check("b2b3_data", bus.rd_data, 32'hA3);

        // Release with a read in the same cycle; it still completes.
        bus.rd_req = 1'b1; bus.rd_addr = 10'd1; bus.consume_done = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0; bus.consume_done = 1'b0;
        check("rel_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("rel_rd_data", bus.rd_data, 32'hA1);
        check("rel_buf_ready", 32'(bus.buf_ready), 32'd0);
        check("rel_tready", 32'(bus.s_axis_tready), 32'd1);

        // Read request while IDLE is ignored.
        bus.rd_req = 1'b1; bus.rd_addr = 10'd0;
        #1;
        check("idle_rd_ena", 32'(bus.ena), 32'd0);
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);

        // 520-beat overflowing frame.
        wr_log.delete();
        for (int i = 0; i < 520; i++) send(32'h1000 + 32'(i), i == 519);
        idle_cycles(1);
        check("ovf_nwr", 32'(wr_log.size()), 32'd512);
        if (wr_log.size() > 0)
            check("ovf_last_addr", wr_log[wr_log.size()-1], 32'd2044);
        check("ovf_err", 32'(bus.err_overflow), 32'd1);
        check("ovf_buf_words", 32'(bus.buf_words), 32'd512);
        check("ovf_buf_ready", 32'(bus.buf_ready), 32'd1);
        bus.rd_req = 1'b1; bus.rd_addr = 10'd511;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("ovf_rd511", bus.rd_data, 32'h11FF);
        consume();

        // One-beat frame clears the sticky overflow.
        wr_log.delete();
        send(32'hBEEF, 1'b1);
        idle_cycles(1);
        check("one_err", 32'(bus.err_overflow), 32'd0);
        check("one_buf_words", 32'(bus.buf_words), 32'd1);
        check("one_buf_ready", 32'(bus.buf_ready), 32'd1);
        check("one_addr", wr_log.size() > 0 ? wr_log[0] : 32'hFFFF_FFFF, 32'd0);
        consume();

        // Gapped 3-beat frame: one beat on, two cycles off.
        wr_log.delete();
        for (int i = 0; i < 3; i++) begin
            send(32'hC0 + 32'(i), i == 2);
            idle_cycles(2);
        end
        check("gap_nwr", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < wr_log.size(); i++)
            check($sformatf("gap_addr%0d", i), wr_log[i], 32'(4 * i));
        check("gap_buf_words", 32'(bus.buf_words), 32'd3);
        consume();

        // Reset pulsed mid-load after two beats.
        send(32'hD0, 1'b0);
        send(32'hD1, 1'b0);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b1;
        wr_log.delete();
        send(32'hE0, 1'b0);
        send(32'hE1, 1'b1);
        idle_cycles(1);
        check("post_rst_addr0", wr_log.size() > 0 ? wr_log[0] : 32'hFFFF_FFFF, 32'd0);
        check("post_rst_addr1", wr_log.size() > 1 ? wr_log[1] : 32'hFFFF_FFFF, 32'd4);
        check("post_rst_words", 32'(bus.buf_words), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
